// File: rtl/branch_predictor_table.sv
// Saturating-counter branch predictor table: bimodal, or gshare when HIST_W > 0.
// A power-up sweep writes INIT into every counter before lookups and updates are accepted.
module branch_predictor_table #(
   parameter int IDX_W  = 6,
   parameter int CTR_W  = 2,
   parameter int HIST_W = 0,
   parameter int PC_W   = 32,
   parameter int INIT   = 2**CTR_W - 1,
   localparam int HW    = (HIST_W > 0) ? HIST_W : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            request,
   input  logic [PC_W-1:0] req_pc,
   input  logic            result,
   input  logic [PC_W-1:0] res_pc,
   input  logic            taken,
   input  logic [HW-1:0]   res_hist,
   output logic            ready,
   output logic            prediction,
   output logic            pred_valid,
   output logic [HW-1:0]   pred_hist,
   output logic [HW-1:0]   ghr
);

   localparam int               ENTRIES = 2**IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state;
   logic [IDX_W-1:0] sweep_ptr;
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] up_idx;
   logic [HW-1:0]    up_hist;
   logic [HW-1:0]    ghr_next;
   logic [CTR_W-1:0] up_ctr;
   logic [CTR_W-1:0] up_next;
   logic [CTR_W-1:0] ctr_mem [ENTRIES];
   logic             unused_pc_bits;

   assign ready          = (state == S_RUN);
   assign up_hist        = (HIST_W > 0) ? res_hist : '0;
   assign lk_idx         = req_pc[IDX_W+1:2] ^ IDX_W'(ghr);
   assign up_idx         = res_pc[IDX_W+1:2] ^ IDX_W'(up_hist);
   assign unused_pc_bits = ^{req_pc, res_pc};

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      up_ctr  = ctr_mem[up_idx];
      up_next = up_ctr;
      if (taken && up_ctr != CTR_MAX)
         up_next = up_ctr + 1'b1;
      else if (!taken && up_ctr != '0)
         up_next = up_ctr - 1'b1;
      ghr_next    = ghr << 1;
      ghr_next[0] = taken;
   end

   // NOTE: the counter array has no reset; the INIT sweep rewrites every entry while ready is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT)
            ctr_mem[sweep_ptr] <= CTR_W'(INIT);
         else if (result)
            ctr_mem[up_idx] <= up_next;
      end
   end

   // Lookups read ctr_mem and ghr before this edge's update lands (read-before-write).
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         sweep_ptr  <= '0;
         pred_valid <= 1'b0;
         prediction <= 1'b0;
         pred_hist  <= '0;
         ghr        <= '0;
      end else begin
         pred_valid <= 1'b0;
         case (state)
            S_INIT: begin
               sweep_ptr <= sweep_ptr + 1'b1;
               if (sweep_ptr == IDX_W'(ENTRIES - 1))
                  state <= S_RUN;
            end
            S_RUN: begin
               pred_valid <= request;
               if (request) begin
                  prediction <= ctr_mem[lk_idx][CTR_W-1];
                  pred_hist  <= ghr;
               end
               if (result && HIST_W > 0)
                  ghr <= ghr_next;
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: doc/branch_predictor_table.md
BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 SHALL have parameter IDX_W, default 6, log2 of table entries (2^IDX_W counters).
REQ-002 SHALL have parameter CTR_W, default 2, saturating counter width (2..4).
REQ-003 SHALL have parameter HIST_W, default 0, global history length (0 = pure bimodal; 0..IDX_W).
REQ-004 SHALL have parameter PC_W, default 32, branch address width (PC_W >= IDX_W+2).
REQ-005 SHALL have parameter INIT, default 2^CTR_W-1, counter value written on reset (strongly taken).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 request  in  1  prediction lookup strobe.
REQ-010 req_pc  in  PC_W  address of branch being predicted.
REQ-011 result  in  1  resolved-branch update strobe.
REQ-012 res_pc  in  PC_W  address of resolved branch.
REQ-013 taken  in  1  resolved outcome (1 = taken).
REQ-014 res_hist  in  max(HIST_W,1)  history snapshot returned with the resolved branch (ignored when HIST_W=0).
REQ-015 ready  out  1  table initialised, accepting request/result.
REQ-016 prediction  out  1  registered prediction (1 = taken).
REQ-017 pred_valid  out  1  one-cycle pulse, prediction/pred_hist valid.
REQ-018 pred_hist  out  max(HIST_W,1)  history used to form this prediction (0 when HIST_W=0).
REQ-019 ghr  out  max(HIST_W,1)  current global history register (0 when HIST_W=0).

Function
REQ-020 Index SHALL be pc[IDX_W+1:2] XOR (history zero-extended to IDX_W); history = ghr for lookup, res_hist for update; pc[1:0] ignored.
REQ-021 FSM states INIT and RUN; rst forces INIT with sweep pointer 0; INIT writes INIT to one entry per cycle, pointer+1; after entry 2^IDX_W-1 goes RUN; total INIT = 2^IDX_W cycles after rst deasserts.
REQ-022 ready SHALL be 0 in INIT, 1 in RUN; request and result while ready=0 SHALL be ignored (no output, no state change).
REQ-023 Lookup: request in RUN at edge N SHALL produce pred_valid=1 for exactly the cycle after edge N, prediction = MSB of indexed counter, pred_hist = ghr sampled at edge N; latency 1 cycle, one lookup per cycle, back-to-back allowed.
REQ-024 prediction and pred_hist SHALL hold their last values when pred_valid=0.
REQ-025 Update: result in RUN SHALL increment indexed counter if taken and counter < 2^CTR_W-1, decrement if !taken and counter > 0, otherwise leave it (saturate, no wrap).
REQ-026 Update SHALL shift ghr left by one with taken in bit 0, dropping the MSB (non-speculative history); no shift when HIST_W=0.
REQ-027 Simultaneous request and result on the same edge: lookup SHALL use counter and ghr values from before that edge's update (read-before-write), same or different index.
REQ-028 One update per cycle; no back-pressure; update and lookup never stall each other in RUN.

Reset
REQ-029 On rst: ready=0, pred_valid=0, prediction=0, pred_hist=0, ghr=0, FSM=INIT, sweep pointer=0.
REQ-030 rst asserted mid-INIT or mid-RUN SHALL restart the full sweep; counters not yet rewritten are never visible because ready=0.
REQ-031 rst has priority over request and result on the same edge.

Verification
REQ-032 IDX_W=4: deassert rst -> ready=0 for 16 cycles, 1 from cycle 17; request pc=0x40 at first ready cycle -> next cycle pred_valid=1, prediction=1.
REQ-033 CTR_W=2, HIST_W=0: 4x result pc=0x40 taken=0 -> counter 3->2->1->0->0; request -> prediction=0; 2x taken=1 -> prediction=1 (counter 2).
REQ-034 Same edge request+result pc=0x40, counter=2, taken=0 -> prediction=1 (old value); next request -> prediction=0.
REQ-035 HIST_W=2: results taken=1,0,1 -> ghr=2'b01; request pc=0x0 uses index 1, pred_hist=2'b01; aliasing check pc=0x4 with ghr=0 hits same entry.
REQ-036 Assert rst mid-RUN after training entries to 0 -> ready drops, 2^IDX_W-cycle sweep reruns, all lookups return prediction=1.
REQ-037 request/result while ready=0 -> no pred_valid, counters and ghr unchanged.
